pattern_sequencer: RTL and testbench
====================================

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter NUM_PATTERNS, default 7, number of valid pattern codes (0..NUM_PATTERNS-1).
REQ-002 Parameter FRAMES_PER_PATTERN, default 120, frames each pattern is shown in auto mode (legal range 1..65535).
REQ-003 Parameter INIT_PATTERN, default 5, pattern code loaded at reset.
REQ-004 i_clk  in  1  pixel clock; the block uses only this clock.
REQ-005 i_reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_vsync  in  1  vertical sync, active-high; a 0->1 transition marks the frame boundary.
REQ-007 i_auto_en  in  1  level; 1 enables auto-cycling.
REQ-008 i_next_req  in  1  single-cycle pulse; request to advance to the next pattern.
REQ-009 i_sel_valid  in  1  direct-select valid.
REQ-010 i_sel_pattern  in  4  direct-select pattern code.
REQ-011 o_sel_ready  out  1  direct-select ready.
REQ-012 o_pattern  out  4  registered pattern code for the test-pattern generator select input.
REQ-013 o_pending  out  1  a change is latched and waits for a frame boundary.
REQ-014 o_changed  out  1  single-cycle pulse in the cycle after o_pattern is updated.

Function
REQ-015 The block SHALL register i_vsync into vsync_q; boundary = i_vsync & ~vsync_q.
REQ-016 FSM states: IDLE and PEND; o_sel_ready = (state == IDLE); o_pending = (state == PEND).
REQ-017 In IDLE, i_sel_valid=1 SHALL latch i_sel_pattern into the pending register and enter PEND; codes >= NUM_PATTERNS SHALL be latched as 0.
REQ-018 In IDLE with i_sel_valid=0, i_next_req=1 SHALL latch (o_pattern+1) mod NUM_PATTERNS and enter PEND.
REQ-019 If i_sel_valid and i_next_req are both 1 in the same cycle, select SHALL win and the next request SHALL be dropped.
REQ-020 In PEND, i_next_req SHALL be ignored, and i_sel_valid SHALL be held off because o_sel_ready=0.
REQ-021 In PEND on a boundary cycle, o_pattern SHALL take the pending value at the next clock edge, the FSM SHALL return to IDLE, and the frame counter SHALL clear.
REQ-022 A request accepted in the same cycle as a boundary SHALL NOT apply at that boundary; it SHALL apply at the following boundary.
REQ-023 Frame counter: 16 bits; it SHALL increment on each boundary while i_auto_en=1 and state=IDLE, and SHALL hold at 0 while i_auto_en=0.
REQ-024 In IDLE with i_auto_en=1, on a boundary with counter == FRAMES_PER_PATTERN-1: o_pattern <= (o_pattern+1) mod NUM_PATTERNS and counter <= 0.
REQ-025 A pending change and an auto-advance at the same boundary: the pending change SHALL win and the counter SHALL clear.
REQ-026 Wrap-around: o_pattern = NUM_PATTERNS-1 SHALL advance to 0.
REQ-027 o_changed SHALL pulse exactly once per o_pattern update, including an update to the same code.
REQ-028 Latency: o_pattern changes 1 clock after the cycle in which i_vsync is first sampled 1 following a sampled 0.
REQ-029 o_pattern SHALL NOT change at any time other than a boundary.

Reset
REQ-030 While i_reset_n=0: o_pattern=INIT_PATTERN, state=IDLE, counter=0, pending=0, o_changed=0, vsync_q=1.
REQ-031 Effect of vsync_q=1: the first boundary after reset requires i_vsync to be sampled 0 first.
REQ-032 Reset asserted mid-PEND SHALL discard the pending change.
REQ-033 o_sel_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-034 video_pkg SHALL hold PATTERN_W=4, the pattern code enum (PAT_OFF=0 .. PAT_BORDER=6), and the seq_state_t enum.
REQ-035 The boundary detector SHALL be a sub-module, frame_edge_detect; the FSM, frame counter and output registers SHALL live in pattern_sequencer.

Verification
REQ-036 Reset release with i_vsync=1 held -> o_pattern=5, no o_changed pulse.
REQ-037 Select 3 accepted mid-frame, then i_vsync 0->1 -> o_pending=1 until the boundary; o_pattern=3 one cycle after the boundary; o_changed pulses once.
REQ-038 o_pattern=6, i_next_req pulse, then boundary -> o_pattern=0.
REQ-039 i_sel_valid=1 with code 2 and i_next_req in the same cycle, at a boundary -> o_pattern unchanged at that boundary; o_pattern=2 at the next boundary.
REQ-040 FRAMES_PER_PATTERN=2, i_auto_en=1, 6 frames from o_pattern=0 -> o_pattern sequence 1,2,3 at boundaries 2,4,6.
REQ-041 i_reset_n pulsed low while PEND (pending 4) -> o_pattern=5, o_pending=0; no change at the next boundary.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types for the video test-pattern path: pattern code width,
// the named pattern codes and the sequencer state encoding.
package video_pkg;

    localparam int PATTERN_W = 4;

    typedef enum logic [PATTERN_W-1:0] {
        PAT_OFF        = 4'd0,
        PAT_COLOR_BARS = 4'd1,
        PAT_RAMP       = 4'd2,
        PAT_CHECKER    = 4'd3,
        PAT_GRID       = 4'd4,
        PAT_SOLID      = 4'd5,
        PAT_BORDER     = 4'd6
    } pattern_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } seq_state_t;

    // Successor code with wrap to 0 after the last legal code.
    function automatic logic [PATTERN_W-1:0] next_code(
        input logic [PATTERN_W-1:0] code,
        input logic [PATTERN_W-1:0] last
    );
        return (code >= last) ? '0 : code + 1'b1;
    endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Rising-edge detector on vsync; the history flop resets high so a
// boundary needs vsync to be seen low at least once after reset.
module frame_edge_detect (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_vsync,
    output logic o_boundary
);

    logic vsync_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vsync_q <= 1'b1;
        end else begin
            vsync_q <= i_vsync;
        end
    end

    assign o_boundary = i_vsync & ~vsync_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Selects the active test pattern; direct selects and next requests are
// held pending and only take effect on a frame boundary, with optional auto-cycling.
module pattern_sequencer
    import video_pkg::*;
#(
    parameter int NUM_PATTERNS       = 7,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int INIT_PATTERN       = 5
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_vsync,
    input  logic                 i_auto_en,
    input  logic                 i_next_req,
    input  logic                 i_sel_valid,
    input  logic [PATTERN_W-1:0] i_sel_pattern,
    output logic                 o_sel_ready,
    output logic [PATTERN_W-1:0] o_pattern,
    output logic                 o_pending,
    output logic                 o_changed
);

    localparam logic [PATTERN_W-1:0] INIT_CODE  = PATTERN_W'(INIT_PATTERN);
    localparam logic [PATTERN_W-1:0] LAST_CODE  = PATTERN_W'(NUM_PATTERNS - 1);
    localparam logic [15:0]          LAST_FRAME = 16'(FRAMES_PER_PATTERN - 1);

    logic                 boundary;
    logic [PATTERN_W-1:0] sel_code;

    seq_state_t           state_reg, state_next;
    logic [PATTERN_W-1:0] pending_reg, pending_next;
    logic [PATTERN_W-1:0] pattern_reg, pattern_next;
    logic [15:0]          frame_cnt_reg, frame_cnt_next;
    logic                 changed_reg, changed_next;

    frame_edge_detect u_edge (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_vsync    (i_vsync),
        .o_boundary (boundary)
    );

    // Out-of-range select codes fall back to pattern 0.
    assign sel_code = (int'(i_sel_pattern) >= NUM_PATTERNS) ? '0 : i_sel_pattern;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg     <= ST_IDLE;
            pending_reg   <= '0;
            pattern_reg   <= INIT_CODE;
            frame_cnt_reg <= '0;
            changed_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pending_reg   <= pending_next;
            pattern_reg   <= pattern_next;
            frame_cnt_reg <= frame_cnt_next;
            changed_reg   <= changed_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pending_next   = pending_reg;
        pattern_next   = pattern_reg;
        frame_cnt_next = frame_cnt_reg;
        changed_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!i_auto_en) begin
                    frame_cnt_next = '0;
                end else if (boundary) begin
                    if (frame_cnt_reg == LAST_FRAME) begin
                        pattern_next   = next_code(pattern_reg, LAST_CODE);
                        changed_next   = 1'b1;
                        frame_cnt_next = '0;
                    end else begin
                        frame_cnt_next = frame_cnt_reg + 16'd1;
                    end
                end
                // A request taken on a boundary cycle waits for the following boundary.
                if (i_sel_valid) begin
                    pending_next = sel_code;
                    state_next   = ST_PEND;
                end else if (i_next_req) begin
                    pending_next = next_code(pattern_next, LAST_CODE);
                    state_next   = ST_PEND;
                end
            end
            ST_PEND: begin
                if (!i_auto_en) begin
                    frame_cnt_next = '0;
                end
                if (boundary) begin
                    pattern_next   = pending_reg;
                    changed_next   = 1'b1;
                    frame_cnt_next = '0;
                    state_next     = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign o_sel_ready = (state_reg == ST_IDLE);
    assign o_pending   = (state_reg == ST_PEND);
    assign o_pattern   = pattern_reg;
    assign o_changed   = changed_reg;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Scenario bench for pattern_sequencer: a default-parameter instance for
// select/next/reset behaviour and a short-cycle instance for auto mode.
module tb_pattern_sequencer;
    import video_pkg::*;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       vsync = 1'b1;
    logic       auto_en = 1'b0;
    logic       next_req = 1'b0;
    logic       sel_valid = 1'b0;
    logic [3:0] sel_pattern = 4'd0;
    logic       sel_ready;
    logic [3:0] pattern;
    logic       pending;
    logic       changed;

    logic       a_vsync = 1'b0;
    logic       a_auto_en = 1'b0;
    logic       a_next_req = 1'b0;
    logic       a_sel_valid = 1'b0;
    logic [3:0] a_sel_pattern = 4'd0;
    logic       a_sel_ready;
    logic [3:0] a_pattern;
    logic       a_pending;
    logic       a_changed;

    int         total = 0;
    int         bad = 0;
    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];
    logic [3:0] exp_a[$];
    logic [3:0] obs_a[$];
    logic [3:0] edge_pat;
    logic       edge_chg;
    logic [3:0] got;
    logic [3:0] want;

    pattern_sequencer dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_vsync       (vsync),
        .i_auto_en     (auto_en),
        .i_next_req    (next_req),
        .i_sel_valid   (sel_valid),
        .i_sel_pattern (sel_pattern),
        .o_sel_ready   (sel_ready),
        .o_pattern     (pattern),
        .o_pending     (pending),
        .o_changed     (changed)
    );

    pattern_sequencer #(
        .NUM_PATTERNS       (7),
        .FRAMES_PER_PATTERN (2),
        .INIT_PATTERN       (0)
    ) dut_auto (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_vsync       (a_vsync),
        .i_auto_en     (a_auto_en),
        .i_next_req    (a_next_req),
        .i_sel_valid   (a_sel_valid),
        .i_sel_pattern (a_sel_pattern),
        .o_sel_ready   (a_sel_ready),
        .o_pattern     (a_pattern),
        .o_pending     (a_pending),
        .o_changed     (a_changed)
    );

    // Advance one clock; outputs are sampled on the falling edge and every
    // o_changed pulse is captured with the pattern it announces.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (changed === 1'b1) obs_q.push_back(pattern);
        if (a_changed === 1'b1) obs_a.push_back(a_pattern);
    endtask

    // One vsync rising edge then low again; records the state right after the edge.
    task automatic frame();
        vsync = 1'b1;
        tick();
        edge_pat = pattern;
        edge_chg = changed;
        vsync = 1'b0;
        tick();
        $display("frame: pattern=%0d changed_at_edge=%0d pending=%0d", pattern, edge_chg, pending);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vsync = 1'b1;
        tick();
        tick();
        total++;
        if (pattern !== 4'(PAT_SOLID)) begin
            bad++; $display("FAIL reset_pattern got=%0d want=5", pattern);
        end
        total++;
        if (pending !== 1'b0 || sel_ready !== 1'b1 || changed !== 1'b0) begin
            bad++; $display("FAIL reset_flags got pend=%0b rdy=%0b chg=%0b want 0/1/0", pending, sel_ready, changed);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (sel_ready !== 1'b1) begin
            bad++; $display("FAIL ready_after_release got=%0b want=1", sel_ready);
        end
        repeat (4) tick();
        total++;
        if (pattern !== 4'd5 || obs_q.size() != 0) begin
            bad++; $display("FAIL vsync_held got pattern=%0d pulses=%0d want 5/0", pattern, obs_q.size());
            obs_q.delete();
        end
        vsync = 1'b0;
        tick();
        $display("reset: pattern=%0d ready=%0b", pattern, sel_ready);
    endtask

    task automatic test_select();
        sel_valid = 1'b1;
        sel_pattern = 4'd3;
        exp_q.push_back(4'(PAT_CHECKER));
        tick();
        sel_valid = 1'b0;
        total++;
        if (pending !== 1'b1 || sel_ready !== 1'b0) begin
            bad++; $display("FAIL select_pending got pend=%0b rdy=%0b want 1/0", pending, sel_ready);
        end
        next_req = 1'b1;
        tick();
        next_req = 1'b0;
        tick();
        total++;
        if (pending !== 1'b1 || pattern !== 4'd5 || obs_q.size() != 0) begin
            bad++; $display("FAIL select_hold got pend=%0b pattern=%0d pulses=%0d want 1/5/0", pending, pattern, obs_q.size());
        end
        frame();
        total++;
        if (edge_pat !== 4'd3 || edge_chg !== 1'b1 || pending !== 1'b0) begin
            bad++; $display("FAIL select_apply got pattern=%0d chg=%0b pend=%0b want 3/1/0", edge_pat, edge_chg, pending);
        end
        total++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            bad++; $display("FAIL select_sb got %0d pulses for %0d expected", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin bad++; $display("FAIL select_sb got=%0d want=%0d", got, want); end
        end
    endtask

    task automatic test_wrap();
        sel_valid = 1'b1;
        sel_pattern = 4'd6;
        exp_q.push_back(4'd6);
        tick();
        sel_valid = 1'b0;
        frame();
        total++;
        if (edge_pat !== 4'd6) begin
            bad++; $display("FAIL wrap_setup got=%0d want=6", edge_pat);
        end
        next_req = 1'b1;
        exp_q.push_back(4'd0);
        tick();
        next_req = 1'b0;
        frame();
        total++;
        if (edge_pat !== 4'd0 || edge_chg !== 1'b1) begin
            bad++; $display("FAIL wrap_apply got pattern=%0d chg=%0b want 0/1", edge_pat, edge_chg);
        end
        total++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            bad++; $display("FAIL wrap_sb got %0d pulses for %0d expected", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                got = obs_q.pop_front(); want = exp_q.pop_front();
                if (got !== want) begin bad++; $display("FAIL wrap_sb[%0d] got=%0d want=%0d", i, got, want); end
            end
        end
    endtask

    task automatic test_same_code();
        sel_valid = 1'b1;
        sel_pattern = 4'd0;
        exp_q.push_back(4'd0);
        tick();
        sel_valid = 1'b0;
        frame();
        total++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            bad++; $display("FAIL same_code_pulse got %0d pulses for %0d expected", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin bad++; $display("FAIL same_code_sb got=%0d want=%0d", got, want); end
        end
    endtask

    task automatic test_collide();
        vsync = 1'b1;
        sel_valid = 1'b1;
        sel_pattern = 4'd2;
        next_req = 1'b1;
        exp_q.push_back(4'(PAT_RAMP));
        tick();
        sel_valid = 1'b0;
        next_req = 1'b0;
        total++;
        if (pattern !== 4'd0 || changed !== 1'b0 || pending !== 1'b1) begin
            bad++; $display("FAIL collide_edge got pattern=%0d chg=%0b pend=%0b want 0/0/1", pattern, changed, pending);
        end
        vsync = 1'b0;
        tick();
        frame();
        total++;
        if (edge_pat !== 4'd2) begin
            bad++; $display("FAIL collide_apply got=%0d want=2", edge_pat);
        end
        total++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            bad++; $display("FAIL collide_sb got %0d pulses for %0d expected", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end else begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            if (got !== want) begin bad++; $display("FAIL collide_sb got=%0d want=%0d", got, want); end
        end
    endtask

    task automatic test_invalid_code();
        sel_valid = 1'b1;
        sel_pattern = 4'd9;
        exp_q.push_back(4'd0);
        tick();
        sel_valid = 1'b0;
        frame();
        total++;
        if (edge_pat !== 4'd0 || obs_q.size() != 1) begin
            bad++; $display("FAIL invalid_code got pattern=%0d pulses=%0d want 0/1", edge_pat, obs_q.size());
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        sel_valid = 1'b1;
        sel_pattern = 4'd1;
        exp_q.push_back(4'd1);
        tick();
        sel_valid = 1'b0;
        vsync = 1'b1;
        tick();
        total++;
        if (pattern !== 4'd1 || sel_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_first got pattern=%0d rdy=%0b want 1/1", pattern, sel_ready);
        end
        sel_valid = 1'b1;
        sel_pattern = 4'd4;
        exp_q.push_back(4'd4);
        tick();
        sel_valid = 1'b0;
        vsync = 1'b0;
        tick();
        frame();
        total++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            bad++; $display("FAIL b2b_sb got %0d pulses for %0d expected", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                got = obs_q.pop_front(); want = exp_q.pop_front();
                if (got !== want) begin bad++; $display("FAIL b2b_sb[%0d] got=%0d want=%0d", i, got, want); end
            end
        end
    endtask

    task automatic test_reset_mid_pend();
        sel_valid = 1'b1;
        sel_pattern = 4'd4;
        tick();
        sel_valid = 1'b0;
        total++;
        if (pending !== 1'b1) begin
            bad++; $display("FAIL rst_pend_setup got pend=%0b want=1", pending);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (pattern !== 4'd5 || pending !== 1'b0) begin
            bad++; $display("FAIL rst_pend_async got pattern=%0d pend=%0b want 5/0", pattern, pending);
        end
        tick();
        rst_n = 1'b1;
        tick();
        frame();
        total++;
        if (edge_pat !== 4'd5 || obs_q.size() != 0) begin
            bad++; $display("FAIL rst_pend_discard got pattern=%0d pulses=%0d want 5/0", edge_pat, obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_auto();
        obs_a.delete();
        a_auto_en = 1'b1;
        a_vsync = 1'b0;
        tick();
        for (int f = 1; f <= 6; f++) begin
            if (f % 2 == 0) exp_a.push_back(4'(f / 2));
            a_vsync = 1'b1;
            tick();
            want = 4'(f / 2);
            total++;
            if (a_pattern !== want || a_pending !== 1'b0 || a_sel_ready !== 1'b1) begin
                bad++; $display("FAIL auto_frame%0d got pattern=%0d pend=%0b rdy=%0b want %0d/0/1", f, a_pattern, a_pending, a_sel_ready, want);
            end
            $display("auto frame %0d: pattern=%0d changed=%0b", f, a_pattern, a_changed);
            a_vsync = 1'b0;
            tick();
        end
        total++;
        if (obs_a.size() != 3 || exp_a.size() != 3) begin
            bad++; $display("FAIL auto_sb got %0d pulses for %0d expected", obs_a.size(), exp_a.size());
            obs_a.delete(); exp_a.delete();
        end else begin
            for (int i = 0; i < 3; i++) begin
                got = obs_a.pop_front(); want = exp_a.pop_front();
                if (got !== want) begin bad++; $display("FAIL auto_sb[%0d] got=%0d want=%0d", i, got, want); end
            end
        end
        a_auto_en = 1'b0;
        for (int f = 0; f < 3; f++) begin
            a_vsync = 1'b1; tick();
            a_vsync = 1'b0; tick();
        end
        total++;
        if (a_pattern !== 4'd3 || obs_a.size() != 0) begin
            bad++; $display("FAIL auto_off got pattern=%0d pulses=%0d want 3/0", a_pattern, obs_a.size());
        end
    endtask

    initial begin
        test_reset();
        test_select();
        test_wrap();
        test_same_code();
        test_collide();
        test_invalid_code();
        test_back_to_back();
        test_reset_mid_pend();
        test_auto();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
